// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl
// Conditions raw speed/direction requests before they reach the PWM/H-bridge
// driver. The requested level is synchronised and clamped to 0..9, and the
// output level moves by at most one step every STEP_CYCLES clocks. A change
// of direction first ramps the level to 0, then holds 0 for DEAD_CYCLES
// clocks, and only then commits the new direction. The motor is therefore
// never reversed while it is still turning.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   speed_req  requested level 0..15 (10..15 are treated as 9), asynchronous
//   turn_req   requested direction (1 = right, 0 = left), asynchronous
//   speed      ramped level to the driver, 0..9, registered
//   turn       committed direction to the driver, registered
//   busy       high whenever the FSM is not in HOLD, registered
//   state_o    FSM state for debug: HOLD=0, RAMP_UP=1, RAMP_DOWN=2, DEAD=3
module speed_ramp_ctrl #(
  parameter int STEP_CYCLES = 5000000,
  parameter int DEAD_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] speed_req,
  input  logic       turn_req,
  output logic [3:0] speed,
  output logic       turn,
  output logic       busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DEAD      = 2'd3
  } state_t;

  localparam int CNT_MAX = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  logic [3:0]    spd_s1_q, spd_s2_q;
  logic          trn_s1_q, trn_s2_q;
  state_t        state_q, state_d;
  logic [3:0]    speed_q, speed_d;
  logic          turn_q, turn_d;
  logic          busy_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    tgt_s;
  logic [3:0]    eff_s;
  logic [3:0]    spd_n_s;
  logic          rev_s;
  logic          step_s;

  // Two-flop synchronisers; turn resets to 1 so no reversal is seen after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_s1_q <= 4'd0;
      spd_s2_q <= 4'd0;
      trn_s1_q <= 1'b1;
      trn_s2_q <= 1'b1;
    end else begin
      spd_s1_q <= speed_req;
      spd_s2_q <= spd_s1_q;
      trn_s1_q <= turn_req;
      trn_s2_q <= trn_s1_q;
    end
  end

  // Clamped target, pending-reversal flag and the effective target during a reversal.
  always_comb begin
    tgt_s  = (spd_s2_q > 4'd9) ? 4'd9 : spd_s2_q;
    rev_s  = (trn_s2_q != turn_q);
    eff_s  = rev_s ? 4'd0 : tgt_s;
    step_s = (cnt_q == STEP_LAST);
  end

  // Next-state, next-speed, next-direction and counter logic.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    spd_n_s = speed_q;
    case (state_q)
      HOLD: begin
        cnt_d = CNT_ZERO;
        if (rev_s) begin
          state_d = (speed_q != 4'd0) ? RAMP_DOWN : DEAD;
        end else if (tgt_s > speed_q) begin
          state_d = RAMP_UP;
        end else if (tgt_s < speed_q) begin
          state_d = RAMP_DOWN;
        end else begin
          state_d = HOLD;
        end
      end
      RAMP_UP: begin
        if (rev_s) begin
          // Reversal wins: no step this cycle, start ramping down next edge.
          state_d = RAMP_DOWN;
        end else begin
          if (step_s && (speed_q < 4'd9)) begin
            spd_n_s = speed_q + 4'd1;
          end else begin
            spd_n_s = speed_q;
          end
          speed_d = spd_n_s;
          cnt_d   = step_s ? CNT_ZERO : (cnt_q + CNT_ONE);
          if (spd_n_s == tgt_s) begin
            state_d = HOLD;
          end else if (tgt_s < spd_n_s) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = RAMP_UP;
          end
        end
      end
      RAMP_DOWN: begin
        if (step_s && (speed_q != 4'd0)) begin
          spd_n_s = speed_q - 4'd1;
        end else begin
          spd_n_s = speed_q;
        end
        speed_d = spd_n_s;
        cnt_d   = step_s ? CNT_ZERO : (cnt_q + CNT_ONE);
        if (spd_n_s == eff_s) begin
          state_d = rev_s ? DEAD : HOLD;
        end else if (!rev_s && (tgt_s > spd_n_s)) begin
          state_d = RAMP_UP;
        end else begin
          state_d = RAMP_DOWN;
        end
      end
      DEAD: begin
        speed_d = 4'd0;
        if (!rev_s) begin
          // Request reverted before the dead time elapsed: keep direction.
          state_d = HOLD;
        end else if (cnt_q == DEAD_LAST) begin
          turn_d  = trn_s2_q;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = HOLD;
        speed_d = 4'd0;
        cnt_d   = CNT_ZERO;
      end
    endcase
    // Every state transition restarts the shared counter.
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      speed_q <= 4'd0;
      turn_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      turn_q  <= turn_d;
      busy_q  <= (state_d != HOLD);
      cnt_q   <= cnt_d;
    end
  end

  assign speed   = speed_q;
  assign turn    = turn_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: doc/speed_ramp_ctrl.md
Name: speed_ramp_ctrl

Overview:
- Command-conditioning stage upstream of the PWM/H-bridge driver.
- Takes raw speed-level and direction requests from switches or buttons and drives the driver's speed[3:0] and turn inputs.
- Limits acceleration to one level per STEP_CYCLES clocks.
- On a direction change, ramps to 0, holds a dead time, then flips direction, so the motor is never reversed while moving.

Parameters:
- STEP_CYCLES, 5000000, clocks between successive one-level speed steps (100 ms at 50 MHz); must be ≥2.
- DEAD_CYCLES, 2500000, clocks speed is held at 0 before the direction output changes; must be ≥1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- speed_req  in  4  requested level 0..9, asynchronous source.
- turn_req  in  1  requested direction (1 = right, 0 = left), asynchronous source.
- speed  out  4  ramped level to the PWM driver, 0..9, registered.
- turn  out  1  committed direction to the PWM driver, registered.
- busy  out  1  high whenever state ≠ HOLD, registered.
- state_o  out  2  current FSM state for debug LEDs: HOLD=0, RAMP_UP=1, RAMP_DOWN=2, DEAD=3.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values (rst_n=0, immediate, asynchronous):
  - speed=0, turn=1, busy=0, state=HOLD, counter=0.
  - speed sync flops = 0; turn sync flops = 1 (no spurious reversal after reset).
- Input sync: two flops each on speed_req and turn_req. Sync latency is 2 clocks; FSM reacts on the following edge.
- Clamping: tgt = (speed_sync > 9) ? 9 : speed_sync. Values 10..15 are treated as 9.
- rev = (turn_sync ≠ turn).
- eff = rev ? 0 : tgt.
- Counter: one shared counter, cleared on every state transition and held at 0 in HOLD.
  - In RAMP_UP/RAMP_DOWN, a step fires on the cycle counter == STEP_CYCLES-1; counter then wraps to 0.
  - In DEAD, it counts to DEAD_CYCLES-1.
- HOLD:
  - rev & speed≠0 → RAMP_DOWN.
  - rev & speed==0 → DEAD.
  - else tgt>speed → RAMP_UP.
  - else tgt<speed → RAMP_DOWN.
  - else stay.
- RAMP_UP:
  - rev → RAMP_DOWN the next edge, no step applied that cycle.
  - Else, on a step, speed += 1.
  - When speed (after any step) == tgt → HOLD.
  - tgt < speed → RAMP_DOWN.
- RAMP_DOWN:
  - On a step, speed -= 1.
  - When speed == eff: rev → DEAD, else → HOLD.
  - If !rev & tgt > speed → RAMP_UP.
- DEAD:
  - speed held 0.
  - If !rev (request reverted) → HOLD, turn unchanged.
  - On counter == DEAD_CYCLES-1: turn <= turn_sync, → HOLD.
- Arithmetic and ordering:
  - speed never leaves 0..9; no wrap on ±1.
  - The first step occurs exactly STEP_CYCLES clocks after entering a ramp state.
  - Target changes during a ramp take effect next cycle without restarting the counter, unless the state changes.
- turn changes only on the DEAD exit edge; speed is 0 on that edge and on the edge after.
- Simultaneous events: a rev change takes priority over a speed-target change in every state.
- Reset asserted mid-operation: all outputs return to reset values at once; after release, the FSM starts from HOLD with speed 0.

Test Plan:
- Params STEP_CYCLES=4, DEAD_CYCLES=8 for all runs; start from reset, turn_req=1.
- Ramp up: speed_req 0→5 → speed increments 0,1,2,3,4,5 at 4-clock intervals, first increment 4 clocks after state_o=1. busy=1 throughout the ramp, busy=0 and state_o=0 once speed=5.
- Ramp down: steady at 5, speed_req→2 → speed 4,3,2 at 4-clock intervals, then HOLD. turn stays 1.
- Reversal: steady at 3, turn_req→0 → speed 2,1,0, then state_o=3 for 8 clocks with speed=0. turn changes to 0 on the DEAD exit, then speed ramps back to 3. turn never changes while speed≠0.
- Clamp: speed_req=15 from 0 → speed rises to 9 and stays; no value >9 and no wrap to 0.
- Revert during dead time: in DEAD after a reversal request, turn_req returns to 1 after 3 clocks → HOLD without a turn toggle, then RAMP_UP to tgt.
- Async reset mid-ramp: rst_n low at speed=4 during RAMP_UP, between clock edges → speed=0, turn=1, busy=0 immediately. After release with speed_req=4, the ramp restarts from 0.
